// File: rtl/sccb_slave_regif_pkg.sv
// ----------------------------------------------------------------------------
// sccb_pkg
// Shared definitions for the SCCB responder and its line conditioner:
//   - byte and bit-counter widths
//   - default bus addresses (write 0x42 / read 0x43, device 7'h21)
//   - responder state encoding
// ----------------------------------------------------------------------------
`timescale 1ns / 1ps

package sccb_pkg;

   localparam int BYTE_W    = 8;
   localparam int BIT_CNT_W = 4;

   localparam logic [BIT_CNT_W-1:0] BITS_PER_BYTE = BIT_CNT_W'(BYTE_W);

   localparam logic [7:0] SCCB_WR_ADDR = 8'h42;
   localparam logic [7:0] SCCB_RD_ADDR = 8'h43;

   // 7-bit device address implied by the 8-bit write address.
   localparam logic [6:0] SCCB_DEV_ADDR = SCCB_WR_ADDR[7:1];

   // Value of the R/W bit (LSB of the address byte) that selects a read.
   localparam logic RW_READ = SCCB_RD_ADDR[0];

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ACK_ADDR,
      ST_SUB,
      ST_ACK_SUB,
      ST_WDATA,
      ST_ACK_WR,
      ST_RDATA,
      ST_RACK,
      ST_WAIT_STOP
   } state_t;

endpackage : sccb_pkg

// File: rtl/sccb_slave_regif_if.sv
// ----------------------------------------------------------------------------
// sccb_slave_regif_if
// Bundles the SCCB bus pins and the register-file port of the responder.
//   iSCL, iSDA  : bus lines as seen by the responder (asynchronous)
//   oSDA_OE     : 1 = responder pulls SDA low (open-drain, tristate outside)
//   oWR_EN      : one-clock write strobe, with oWR_ADDR / oWR_DATA
//   oRD_ADDR    : current pointer; register file answers on iRD_DATA
//   oBUSY       : transaction in progress (START .. STOP)
// Modports: slave = responder side, master = bus/register-file side.
// ----------------------------------------------------------------------------
`timescale 1ns / 1ps

interface sccb_slave_regif_if;

   logic       iSCL;
   logic       iSDA;
   logic       oSDA_OE;
   logic       oWR_EN;
   logic [7:0] oWR_ADDR;
   logic [7:0] oWR_DATA;
   logic [7:0] oRD_ADDR;
   logic [7:0] iRD_DATA;
   logic       oBUSY;

   modport slave (
      input  iSCL, iSDA, iRD_DATA,
      output oSDA_OE, oWR_EN, oWR_ADDR, oWR_DATA, oRD_ADDR, oBUSY
   );

   modport master (
      output iSCL, iSDA, iRD_DATA,
      input  oSDA_OE, oWR_EN, oWR_ADDR, oWR_DATA, oRD_ADDR, oBUSY
   );

endinterface : sccb_slave_regif_if

// File: rtl/sccb_line_sync.sv
// ----------------------------------------------------------------------------
// sccb_line_sync
// Brings asynchronous SCL/SDA into the iCLK domain and derives bus events.
//   iCLK, iRST         : system clock, synchronous active-high reset
//   scl_line, sda_line : raw bus lines
//   sda                : synchronized SDA level
//   scl_rise, scl_fall : single-cycle SCL edge pulses
//   start, stop        : single-cycle START / STOP condition pulses
// Each line passes through SYNC_STAGES flops (2 or more) plus one history flop.
// ----------------------------------------------------------------------------
`timescale 1ns / 1ps

module sccb_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic iCLK,
   input  logic iRST,
   input  logic scl_line,
   input  logic sda_line,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_hist;
   logic                   sda_hist;
   logic                   scl;

   // NOTE: sequential state is written with non-blocking assignments so every
   // flop samples the pre-edge value of its neighbour; blocking assignments
   // here would collapse the synchronizer chain into a single stage.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         // NOTE: the chain is reset to the idle-bus level (both lines high) so
         // leaving reset never manufactures an edge, START or STOP.
         scl_sync <= '1;
         sda_sync <= '1;
         scl_hist <= 1'b1;
         sda_hist <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_line};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_line};
         scl_hist <= scl_sync[SYNC_STAGES-1];
         sda_hist <= sda_sync[SYNC_STAGES-1];
      end
   end

   assign scl = scl_sync[SYNC_STAGES-1];
   assign sda = sda_sync[SYNC_STAGES-1];

   assign scl_rise = scl & ~scl_hist;
   assign scl_fall = ~scl & scl_hist;

   // SDA may only move while SCL is high to signal START/STOP, so SCL must be
   // high both now and in the history flop.
   assign start = scl & scl_hist &  sda_hist & ~sda;
   assign stop  = scl & scl_hist & ~sda_hist &  sda;

endmodule : sccb_line_sync

// File: rtl/sccb_slave_regif.sv
// ----------------------------------------------------------------------------
// sccb_slave_regif
// SCCB/I2C responder fronting a generic 8-bit register file.
//   iCLK : system clock, at least 16x the SCL frequency
//   iRST : synchronous active-high reset
//   bus  : sccb_slave_regif_if.slave (SCL/SDA, SDA pull-down enable,
//          write strobe/address/data, read pointer/data, busy)
// Write: START, DEV_ADDR+W, sub-address, data bytes..., STOP.
// Read : START, DEV_ADDR+R, data bytes with master ACK, final NACK, STOP.
// The sub-address pointer survives STOP and repeated START, so a read can
// follow a sub-address-only write.
// ----------------------------------------------------------------------------
`timescale 1ns / 1ps

module sccb_slave_regif
   import sccb_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = SCCB_DEV_ADDR,
   parameter bit         AUTO_INC    = 1'b1,
   parameter int         SYNC_STAGES = 2
) (
   input logic               iCLK,
   input logic               iRST,
   sccb_slave_regif_if.slave bus
);

   logic sda;
   logic scl_rise;
   logic scl_fall;
   logic start_evt;
   logic stop_evt;

   sccb_line_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_line_sync (
      .iCLK     (iCLK),
      .iRST     (iRST),
      .scl_line (bus.iSCL),
      .sda_line (bus.iSDA),
      .sda      (sda),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start_evt),
      .stop     (stop_evt)
   );

   state_t                state,    state_nx;
   logic [BYTE_W-1:0]     shreg,    shreg_nx;
   logic [BIT_CNT_W-1:0]  bit_cnt,  bit_cnt_nx;
   logic [BYTE_W-1:0]     ptr,      ptr_nx;
   logic [BYTE_W-1:0]     wr_addr,  wr_addr_nx;
   logic [BYTE_W-1:0]     wr_data,  wr_data_nx;
   logic                  wr_en,    wr_en_nx;
   logic                  oe,       oe_nx;
   logic                  busy,     busy_nx;

   // The falling SCL edge that ends the 8th bit of a received byte.
   logic byte_done;
   assign byte_done = scl_fall && (bit_cnt == BITS_PER_BYTE);

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state   <= ST_IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         ptr     <= '0;
         wr_addr <= '0;
         wr_data <= '0;
         wr_en   <= 1'b0;
         oe      <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state   <= state_nx;
         shreg   <= shreg_nx;
         bit_cnt <= bit_cnt_nx;
         ptr     <= ptr_nx;
         wr_addr <= wr_addr_nx;
         wr_data <= wr_data_nx;
         wr_en   <= wr_en_nx;
         oe      <= oe_nx;
         busy    <= busy_nx;
      end
   end

   always_comb begin
      // NOTE: every next-state value is defaulted before any branch so no path
      // leaves a variable unassigned, which would infer a latch.
      state_nx   = state;
      shreg_nx   = shreg;
      bit_cnt_nx = bit_cnt;
      ptr_nx     = ptr;
      wr_addr_nx = wr_addr;
      wr_data_nx = wr_data;
      wr_en_nx   = 1'b0;
      oe_nx      = oe;
      busy_nx    = busy;

      if (start_evt) begin
         // START and repeated START: release SDA at once, keep the pointer.
         state_nx   = ST_ADDR;
         bit_cnt_nx = '0;
         oe_nx      = 1'b0;
         busy_nx    = 1'b1;
      end else if (stop_evt) begin
         // Any partial byte is simply dropped.
         state_nx   = ST_IDLE;
         bit_cnt_nx = '0;
         oe_nx      = 1'b0;
         busy_nx    = 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               oe_nx = 1'b0;
            end

            ST_ADDR: begin
               if (scl_rise) begin
                  shreg_nx   = {shreg[BYTE_W-2:0], sda};
                  bit_cnt_nx = bit_cnt + 1'b1;
               end else if (byte_done) begin
                  if (shreg[7:1] == DEV_ADDR) begin
                     oe_nx    = 1'b1;
                     state_nx = ST_ACK_ADDR;
                  end else begin
                     oe_nx    = 1'b0;
                     state_nx = ST_WAIT_STOP;
                  end
               end
            end

            ST_ACK_ADDR: begin
               // shreg still holds the address byte; its LSB is R/W.
               if (scl_fall) begin
                  bit_cnt_nx = '0;
                  if (shreg[0] == RW_READ) begin
                     shreg_nx = bus.iRD_DATA;
                     oe_nx    = ~bus.iRD_DATA[BYTE_W-1];
                     state_nx = ST_RDATA;
                  end else begin
                     oe_nx    = 1'b0;
                     state_nx = ST_SUB;
                  end
               end
            end

            ST_SUB: begin
               if (scl_rise) begin
                  shreg_nx   = {shreg[BYTE_W-2:0], sda};
                  bit_cnt_nx = bit_cnt + 1'b1;
               end else if (byte_done) begin
                  ptr_nx   = shreg;
                  oe_nx    = 1'b1;
                  state_nx = ST_ACK_SUB;
               end
            end

            ST_ACK_SUB, ST_ACK_WR: begin
               if (scl_fall) begin
                  oe_nx      = 1'b0;
                  bit_cnt_nx = '0;
                  state_nx   = ST_WDATA;
               end
            end

            ST_WDATA: begin
               if (scl_rise) begin
                  shreg_nx   = {shreg[BYTE_W-2:0], sda};
                  bit_cnt_nx = bit_cnt + 1'b1;
               end else if (byte_done) begin
                  wr_en_nx   = 1'b1;
                  wr_addr_nx = ptr;
                  wr_data_nx = shreg;
                  oe_nx      = 1'b1;
                  if (AUTO_INC) begin
                     ptr_nx = ptr + 8'd1;
                  end
                  state_nx = ST_ACK_WR;
               end
            end

            ST_RDATA: begin
               // Bit 7 is already on the line on entry; bit_cnt counts the
               // bits the master has clocked in.
               if (scl_rise) begin
                  bit_cnt_nx = bit_cnt + 1'b1;
               end else if (scl_fall) begin
                  if (bit_cnt == BITS_PER_BYTE) begin
                     oe_nx      = 1'b0;
                     bit_cnt_nx = '0;
                     state_nx   = ST_RACK;
                  end else begin
                     shreg_nx = {shreg[BYTE_W-2:0], 1'b0};
                     oe_nx    = ~shreg[BYTE_W-2];
                  end
               end
            end

            ST_RACK: begin
               // bit_cnt doubles as "master ACK seen" so the reload waits for
               // the end of the ACK clock; the pointer steps on the ACK itself,
               // leaving half an SCL period for iRD_DATA to follow.
               if (scl_rise) begin
                  if (sda) begin
                     state_nx = ST_WAIT_STOP;
                  end else begin
                     bit_cnt_nx = {{(BIT_CNT_W-1){1'b0}}, 1'b1};
                     if (AUTO_INC) begin
                        ptr_nx = ptr + 8'd1;
                     end
                  end
               end else if (scl_fall && (bit_cnt != '0)) begin
                  shreg_nx   = bus.iRD_DATA;
                  oe_nx      = ~bus.iRD_DATA[BYTE_W-1];
                  bit_cnt_nx = '0;
                  state_nx   = ST_RDATA;
               end
            end

            ST_WAIT_STOP: begin
               oe_nx = 1'b0;
            end

            default: begin
               oe_nx    = 1'b0;
               state_nx = ST_IDLE;
            end
         endcase
      end
   end

   assign bus.oSDA_OE  = oe;
   assign bus.oWR_EN   = wr_en;
   assign bus.oWR_ADDR = wr_addr;
   assign bus.oWR_DATA = wr_data;
   assign bus.oRD_ADDR = ptr;
   assign bus.oBUSY    = busy;

endmodule : sccb_slave_regif
